// File: rtl/uart_receive_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and baud divisor helper.
// The same package is intended to be imported by uart_send.
package uart_receive_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

    // Clock cycles per bit, e.g. 100 MHz / 115200 baud -> 868.
    function automatic int calc_div(input int clk_mhz, input int baud);
        return (clk_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counter for bit timing; flags expiry at zero and reloads DIV-1 on its own,
// so consecutive bit samples stay exactly DIV cycles apart for the whole frame.
module uart_baud_tick #(
    parameter int DIV = 868,
    parameter int W   = $clog2(DIV)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver with single-cycle valid / frame_err / parity_err strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches.
module uart_receive
    import uart_receive_pkg::*;
#(
    parameter int BAUD    = 115200,
    parameter int CLK_MHZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_MHZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);

    uart_state_t state, state_next;
    logic        rx_meta, rx_sync;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic        load, expire, shift_en;
    logic        valid_set, ferr_set;

    // Idle level is high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_baud_tick #(
        .DIV (DIV),
        .W   (CW)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (HALF_BIT),
        .expire   (expire)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_capture, perr_set;
    logic par_mismatch;
    assign par_mismatch = par_bit ^ (^shift_reg);
`endif

    // NOTE: every signal written here gets a default first, otherwise paths that
    // skip an assignment would infer latches.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        valid_set  = 1'b0;
        ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_capture = 1'b0;
        perr_set    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (expire) state_next = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (expire) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expire) begin
                    par_capture = 1'b1;
                    state_next  = STOP;
                end
            end
`endif
            STOP: begin
                if (expire) begin
                    if (rx_sync) begin
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_mismatch) perr_set = 1'b1;
                        else              valid_set = 1'b1;
`else
                        valid_set = 1'b1;
`endif
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too; they are few flops, and a defined
    // data_byte after reset is part of the interface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            data_byte <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            valid     <= valid_set;
            frame_err <= ferr_set;
            if (state == START) bit_idx <= '0;
            else if (shift_en)  bit_idx <= bit_idx + 3'd1;
            if (shift_en)  shift_reg <= {rx_sync, shift_reg[7:1]};
            if (valid_set) data_byte <= shift_reg;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_set;
            if (par_capture) par_bit <= rx_sync;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: expected bytes are queued as frames are driven and
// popped when valid pulses. A faster baud keeps the run short while DIV/2 stays above 100.
module tb_uart_receive;

    localparam int BAUD    = 400_000;
    localparam int CLK_MHZ = 100;
    localparam int DIV     = (CLK_MHZ * 1_000_000) / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_byte;
    logic       valid, frame_err, parity_err, busy;

    int errors = 0;
    int checks = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0;
    int n_exp_valid = 0, n_exp_ferr = 0, n_exp_perr = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_receive #(
        .BAUD    (BAUD),
        .CLK_MHZ (CLK_MHZ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_byte  (data_byte),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok);
        logic [7:0] d;
        logic       good;
        d = b;
`ifdef UART_RX_PARITY_EN
        good = par_ok;
`else
        good = 1'b1;
`endif
        if (!stop_ok) begin
            n_exp_ferr++;
        end else if (good) begin
            exp_q.push_back(d);
            n_exp_valid++;
        end else begin
            n_exp_perr++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? (^d) : ~(^d));
`endif
        drive_bit(stop_ok);
    endtask

    // Output monitor: count strobes and compare every valid byte with the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (valid || frame_err || parity_err)
                check("one_pulse", 32'(valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
            if (valid) begin
                n_valid++;
                if (exp_q.size() == 0) check("valid_expected", 32'(exp_q.size()), 32'd1);
                else                   check("data_byte", 32'(data_byte), 32'(exp_q.pop_front()));
            end
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_data_byte",  32'(data_byte),  32'h00);
        check("rst_valid",      32'(valid),      32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        rst = 1'b1;
        idle(1);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(1);
        check("a5_held", 32'(data_byte), 32'hA5);

        // Low pulse shorter than half a bit must be rejected as a false start.
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
        check("glitch_busy",     32'(busy),      32'd0);
        check("glitch_data",     32'(data_byte), 32'hA5);
        check("glitch_no_valid", 32'(n_valid),   32'(n_exp_valid));

        send_frame(8'h3C, 1'b1, 1'b0);
        idle(1);
        check("ferr_data_kept", 32'(data_byte), 32'hA5);
        check("ferr_count_1",   32'(n_ferr),    32'(n_exp_ferr));

        // Line held low for two frame times: one frame error, then wait for idle.
        rx = 1'b0;
        repeat (20 * DIV) @(negedge clk);
        n_exp_ferr++;
        idle(1);
        check("break_ferr_count", 32'(n_ferr), 32'(n_exp_ferr));
        check("break_busy",       32'(busy),   32'd0);
        send_frame(8'h11, 1'b1, 1'b1);
        idle(1);

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(1);
        check("b2b_last", 32'(data_byte), 32'h55);

        // Reset asserted in the middle of a data bit of 8'hC3.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (DIV / 2) @(negedge clk);
        check("busy_mid_frame", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_data_byte",  32'(data_byte),  32'h00);
        check("arst_valid",      32'(valid),      32'd0);
        check("arst_frame_err",  32'(frame_err),  32'd0);
        check("arst_parity_err", 32'(parity_err), 32'd0);
        check("arst_busy",       32'(busy),       32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(1);
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(1);
        check("after_rst_data", 32'(data_byte), 32'h7E);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1);
        idle(1);
        send_frame(8'h01, 1'b0, 1'b1);
        idle(1);
        check("perr_data_kept", 32'(data_byte), 32'h01);
`endif

        idle(2);
        check("valid_total",  32'(n_valid),      32'(n_exp_valid));
        check("ferr_total",   32'(n_ferr),       32'(n_exp_ferr));
        check("perr_total",   32'(n_perr),       32'(n_exp_perr));
        check("queue_empty",  32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
